// File: rtl/ring_seq_checker.sv
// ---------------------------------------------------------------------------
// ring_seq_checker
//
// Watches a one-hot "ring" word that should rotate left by one position on
// every valid sample. A three-state FSM hunts for a one-hot word, tracks
// consecutive correct rotations, and declares lock after LOCK_CNT of them.
// Once locked, any word that is not the expected rotation raises a one-cycle
// seq_err pulse and bumps a saturating error counter.
//
// Parameters
//   WIDTH    ring width in bits (2..32)
//   LOCK_CNT consecutive correct rotations needed to lock (1..15)
//   ERR_W    width of the error counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   ring_in holds a sample to evaluate this cycle
//   ring_in    sampled ring word
//   err_clr    clear err_count (a coincident error leaves it at 1)
//   index      binary position of the set bit of the last one-hot sample
//   onehot_ok  last valid sample had exactly one bit set
//   locked     FSM is in LOCKED
//   seq_err    one-cycle pulse on a rotation violation while locked
//   err_count  saturating count of seq_err events
// ---------------------------------------------------------------------------
module ring_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     seq_err,
    output logic [ERR_W-1:0]         err_count
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        LOCKED
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   prev_n;
    logic [3:0]         good_cnt;
    logic [3:0]         good_n;
    logic [3:0]         good_inc;
    logic [WIDTH-1:0]   expected;
    logic               is_onehot;
    logic [IDX_W-1:0]   enc_idx;
    logic               seq_err_n;
    logic [ERR_W-1:0]   err_n;

    // Classify the incoming word. A word is one-hot when it is non-zero and
    // clearing its lowest set bit leaves nothing behind. The encoder only
    // matters for one-hot words, so it simply reports the last set bit seen.
    always_comb begin
        is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
        enc_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    // The word we expect next is prev rotated left with wrap-around, so the
    // top bit comes back in at position zero.
    assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign good_inc = good_cnt + 4'd1;

    // Next-state logic for the hunt/track/lock FSM. Nothing moves unless the
    // sample is valid. A repeated word never equals its own rotation, so it
    // falls out as an ordinary mismatch. Only mismatches seen while locked
    // are reported; in HUNT or TRACK they just restart the tracking.
    always_comb begin
        state_n   = state;
        prev_n    = prev;
        good_n    = good_cnt;
        seq_err_n = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (is_onehot) begin
                        prev_n  = ring_in;
                        good_n  = '0;
                        state_n = TRACK;
                    end
                end
                TRACK: begin
                    if (ring_in == expected) begin
                        prev_n = ring_in;
                        good_n = good_inc;
                        if (good_inc == LOCK_VAL) begin
                            state_n = LOCKED;
                        end
                    end else if (is_onehot) begin
                        prev_n = ring_in;
                        good_n = '0;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (ring_in == expected) begin
                        prev_n = ring_in;
                    end else begin
                        seq_err_n = 1'b1;
                        if (is_onehot) begin
                            prev_n  = ring_in;
                            good_n  = '0;
                            state_n = TRACK;
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    // Error counter update. A clear wins over counting, but an error landing
    // in the same cycle as the clear is still recorded as the first new one.
    // Counting stops at all-ones rather than wrapping back to zero.
    always_comb begin
        err_n = err_count;
        if (err_clr) begin
            err_n = seq_err_n ? ERR_W'(1) : '0;
        end else if (seq_err_n && (err_count != ERR_MAX)) begin
            err_n = err_count + ERR_W'(1);
        end
    end

    // State and output registers. Reset has priority over everything else.
    // The one-hot flag follows every valid sample, while index only moves on
    // a valid one-hot sample so a bad word does not disturb the position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            prev      <= '0;
            good_cnt  <= '0;
            index     <= '0;
            onehot_ok <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            good_cnt  <= good_n;
            seq_err   <= seq_err_n;
            err_count <= err_n;
            if (in_valid) begin
                onehot_ok <= is_onehot;
                if (is_onehot) begin
                    index <= enc_idx;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
